input_port_buffer: RTL and testbench
====================================

// Module: input_port_buffer
// PURPOSE
//  Per-port ingress buffer of the simple_mesh_xy switch: the write side of the link that the switch control unit reads.
//  Accepts flits from a neighbour (wr_en/full handshake), stores them in a circular FIFO and presents empty_o to the control unit.
//  Pops on rd_en_i and returns the flit registered one cycle later, with its XY output-port index decoded from the header.
// PARAMETERS
//  DATA_WIDTH   8  flit width; flit = {dst_x, dst_y, payload}, dst_x in MSBs
//  FIFO_DEPTH   4  entries; power of two, >= 2
//  X_W          2  width of dst_x field
//  Y_W          2  width of dst_y field
//  X_CORD       0  this router's column
//  Y_CORD       0  this router's row
//  PORT_N       5  switch port count (route index width = $clog2(PORT_N))
// PORTS
//  clk_i        in   1                 clock
//  rst_ni       in   1                 async active-low reset
//  wr_en_i      in   1                 upstream write strobe
//  data_i       in   DATA_WIDTH        upstream flit
//  full_o       out  1                 buffer full, upstream must not write
//  rd_en_i      in   1                 pop request from control unit
//  empty_o      out  1                 buffer empty
//  data_o       out  DATA_WIDTH        last popped flit (registered)
//  route_o      out  $clog2(PORT_N)    XY output port of data_o (registered)
//  overflow_o   out  1                 sticky: write attempted while full
//  almost_full_o out 1                 only with INPUT_BUF_ALMOST_FULL_EN
// BEHAVIOUR
//  One clock (clk_i); reset is asynchronous and active-low (rst_ni).
//  Reset: wr_ptr=rd_ptr=0, count=0, empty_o=1, full_o=0, data_o=0, route_o=0, overflow_o=0, almost_full_o=0.
//  Reset mid-operation: contents discarded, outputs return to reset values immediately.
//  count is $clog2(FIFO_DEPTH)+1 bits; full_o = (count==FIFO_DEPTH), empty_o = (count==0), both combinational from count.
//  Push: wr_en_i && !full_o -> mem[wr_ptr]<=data_i, wr_ptr+1 (wraps FIFO_DEPTH-1 -> 0).
//  Write while full: flit dropped, pointers unchanged, overflow_o set (cleared only by reset); holds even if rd_en_i same cycle.
//  Pop: rd_en_i && !empty_o -> data_o<=mem[rd_ptr], route_o<=xy(mem[rd_ptr]), rd_ptr+1 (wraps). 1-cycle latency.
//  rd_en_i while empty: ignored, data_o/route_o hold; a same-cycle write to an empty buffer is not bypassed.
//  Simultaneous push+pop (neither full nor empty): count unchanged, both pointers advance.
//  data_o/route_o hold the last popped flit until the next pop.
//  XY routing (from data_o's header): dst_x>X_CORD -> EAST; dst_x<X_CORD -> WEST;
//   else dst_y>Y_CORD -> SOUTH; dst_y<Y_CORD -> NORTH; else LOCAL.
//  Port encoding: LOCAL=0, NORTH=1, EAST=2, SOUTH=3, WEST=4.
// CONFIGURATION
//  INPUT_BUF_ALMOST_FULL_EN defined: almost_full_o = (count >= FIFO_DEPTH-1), combinational, 0 at reset.
//  Not defined: almost_full_o port absent, no extra logic.
// STRUCTURE
//  Shared package/include noc_params: port index constants (LOCAL..WEST), PORT_N, flit field offsets.
//  Sub-module xy_route_calc: combinational header -> port index.
//  Instantiated once on the pop path, result registered into route_o.
//  FIFO storage, pointers, count and flags live in this module.
// TESTING
//  Formal: never full_o&&empty_o; count<=FIFO_DEPTH; no pointer change on write-while-full or read-while-empty.
//  T1 reset: rst_ni=0 mid-traffic -> empty_o=1, full_o=0, data_o=0, route_o=0, overflow_o=0 same cycle.
//  T2 fill/drain (DEPTH=4): push 0x11,0x22,0x33,0x44 -> full_o=1 after 4th.
//   4 pops -> data_o 0x11..0x44 each 1 cycle after rd_en_i, then empty_o=1.
//  T3 overflow: full, wr_en_i=1 data 0x55 with rd_en_i=1 -> 0x55 dropped, overflow_o=1, count 3 after.
//  T4 wrap: 10 interleaved push/pop pairs at count=2 -> FIFO order preserved across pointer wrap, count stays 2.
//  T5 routing (X_CORD=1,Y_CORD=1, X_W=Y_W=2): headers (2,1)->2, (0,1)->4, (1,2)->3, (1,0)->1, (1,1)->0 on route_o.
//  T6 empty edge: rd_en_i on empty with same-cycle write 0x7A -> data_o unchanged; next-cycle pop returns 0x7A.
//  T7 (macro on): count 3 of 4 -> almost_full_o=1, full_o=0; pop -> almost_full_o=0.

Source files
------------

// File: rtl/input_port_buffer_pkg.sv
// Shared switch parameters for input_port_buffer: output-port indices, port count
// and flit header field placement helpers.
package input_port_buffer_pkg;

  localparam int PORT_N  = 5;
  localparam int ROUTE_W = $clog2(PORT_N);

  typedef enum logic [ROUTE_W-1:0] {
    LOCAL = 3'd0,
    NORTH = 3'd1,
    EAST  = 3'd2,
    SOUTH = 3'd3,
    WEST  = 3'd4
  } port_e;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_X_W        = 2;
  localparam int DEF_Y_W        = 2;

  // Header layout is {dst_x, dst_y, payload} with dst_x in the MSBs.
  function automatic int x_lsb(input int data_width, input int x_w);
    return data_width - x_w;
  endfunction

  function automatic int y_lsb(input int data_width, input int x_w, input int y_w);
    return data_width - x_w - y_w;
  endfunction

endpackage

// File: rtl/input_port_buffer_xy_route_calc.sv
// Combinational dimension-ordered (X then Y) routing: destination coordinates
// to the output-port index of this router.
module xy_route_calc
  import input_port_buffer_pkg::*;
#(
  parameter int X_W     = DEF_X_W,
  parameter int Y_W     = DEF_Y_W,
  parameter int X_CORD  = 0,
  parameter int Y_CORD  = 0,
  parameter int ROUTE_W = input_port_buffer_pkg::ROUTE_W
) (
  input  logic [X_W-1:0]     dst_x,
  input  logic [Y_W-1:0]     dst_y,
  output logic [ROUTE_W-1:0] route
);

  localparam logic [X_W-1:0] X_HERE = X_W'(X_CORD);
  localparam logic [Y_W-1:0] Y_HERE = Y_W'(Y_CORD);

  // X is resolved completely before Y is considered.
  always_comb begin
    route = ROUTE_W'(LOCAL);
    if (dst_x > X_HERE) begin
      route = ROUTE_W'(EAST);
    end else if (dst_x < X_HERE) begin
      route = ROUTE_W'(WEST);
    end else if (dst_y > Y_HERE) begin
      route = ROUTE_W'(SOUTH);
    end else if (dst_y < Y_HERE) begin
      route = ROUTE_W'(NORTH);
    end
  end

endmodule

// File: rtl/input_port_buffer.sv
// Per-port ingress FIFO of the mesh switch with registered pop data and XY route.
// Optional almost_full_o output is enabled by defining INPUT_BUF_ALMOST_FULL_EN.
module input_port_buffer
  import input_port_buffer_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int FIFO_DEPTH = 4,
  parameter int X_W        = DEF_X_W,
  parameter int Y_W        = DEF_Y_W,
  parameter int X_CORD     = 0,
  parameter int Y_CORD     = 0,
  parameter int PORT_N     = input_port_buffer_pkg::PORT_N
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       wr_en_i,
  input  logic [DATA_WIDTH-1:0]      data_i,
  output logic                       full_o,
  input  logic                       rd_en_i,
  output logic                       empty_o,
  output logic [DATA_WIDTH-1:0]      data_o,
  output logic [$clog2(PORT_N)-1:0]  route_o,
  output logic                       overflow_o
`ifdef INPUT_BUF_ALMOST_FULL_EN
  ,
  output logic                       almost_full_o
`endif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int RT_W  = $clog2(PORT_N);
  localparam int XL    = x_lsb(DATA_WIDTH, X_W);
  localparam int YL    = y_lsb(DATA_WIDTH, X_W, Y_W);

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      count;
  logic                  push;
  logic                  pop;
  logic [DATA_WIDTH-1:0] head;
  logic [RT_W-1:0]       head_route;

  assign full_o  = (count == CNT_W'(FIFO_DEPTH));
  assign empty_o = (count == '0);
  assign push    = wr_en_i && !full_o;
  assign pop     = rd_en_i && !empty_o;
  assign head    = mem[rd_ptr];

`ifdef INPUT_BUF_ALMOST_FULL_EN
  assign almost_full_o = (count >= CNT_W'(FIFO_DEPTH - 1));
`endif

  xy_route_calc #(
    .X_W     (X_W),
    .Y_W     (Y_W),
    .X_CORD  (X_CORD),
    .Y_CORD  (Y_CORD),
    .ROUTE_W (RT_W)
  ) u_route (
    .dst_x (head[XL +: X_W]),
    .dst_y (head[YL +: Y_W]),
    .route (head_route)
  );

  // Storage is not reset; the pointers and count define which entries are live.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[wr_ptr] <= data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // A pop only sees entries already stored, so a write into an empty buffer is never bypassed.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_o     <= '0;
      route_o    <= '0;
      overflow_o <= 1'b0;
    end else begin
      if (pop) begin
        data_o  <= head;
        route_o <= head_route;
      end
      if (wr_en_i && full_o) begin
        overflow_o <= 1'b1;
      end
    end
  end

  a_not_full_and_empty : assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(full_o && empty_o));
  a_count_bounded : assert property (@(posedge clk_i) disable iff (!rst_ni)
    count <= CNT_W'(FIFO_DEPTH));
  a_no_wr_ptr_move_when_full : assert property (@(posedge clk_i) disable iff (!rst_ni)
    (wr_en_i && full_o) |=> $stable(wr_ptr));
  a_no_rd_ptr_move_when_empty : assert property (@(posedge clk_i) disable iff (!rst_ni)
    (rd_en_i && empty_o) |=> $stable(rd_ptr));

endmodule

// File: tb/tb_input_port_buffer.sv
// Directed table-driven bench for input_port_buffer (router at X=1, Y=1).
// T7 almost-full checks are compiled only when INPUT_BUF_ALMOST_FULL_EN is defined.
module tb_input_port_buffer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr_en;
  logic [7:0] din;
  logic       full;
  logic       rd_en;
  logic       empty;
  logic [7:0] dout;
  logic [2:0] route;
  logic       overflow;
`ifdef INPUT_BUF_ALMOST_FULL_EN
  logic       almost_full;
`endif

  int vectors    = 0;
  int miscompares = 0;

  typedef struct {
    logic       wr;
    logic [7:0] din;
    logic       rd;
    logic       e_empty;
    logic       e_full;
    logic [7:0] e_data;
    logic [2:0] e_route;
    logic       e_ovf;
  } vec_t;

  vec_t vecs[20];

  input_port_buffer #(
    .DATA_WIDTH (8),
    .FIFO_DEPTH (4),
    .X_W        (2),
    .Y_W        (2),
    .X_CORD     (1),
    .Y_CORD     (1),
    .PORT_N     (5)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .wr_en_i       (wr_en),
    .data_i        (din),
    .full_o        (full),
    .rd_en_i       (rd_en),
    .empty_o       (empty),
    .data_o        (dout),
    .route_o       (route),
    .overflow_o    (overflow)
`ifdef INPUT_BUF_ALMOST_FULL_EN
    ,
    .almost_full_o (almost_full)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference routing for a router at (1,1); header x in [7:6], y in [5:4].
  function automatic logic [2:0] exp_route(input logic [7:0] v);
    logic [1:0] x;
    logic [1:0] y;
    x = v[7:6];
    y = v[5:4];
    if (x > 2'd1)      return 3'd2;
    else if (x < 2'd1) return 3'd4;
    else if (y > 2'd1) return 3'd3;
    else if (y < 2'd1) return 3'd1;
    else               return 3'd0;
  endfunction

  task automatic applyStimulus(input logic wr, input logic [7:0] d, input logic rd);
    @(negedge clk);
    wr_en = wr;
    din   = d;
    rd_en = rd;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    rd_en = 1'b0;
    din   = 8'h00;
  endtask

  task automatic checkBit(input string name, input logic act, input logic exp);
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %b, want %b", name, act, exp);
    end
  endtask

  task automatic checkOutput(input string name, input logic e_empty, input logic e_full,
                             input logic [7:0] e_data, input logic [2:0] e_route,
                             input logic e_ovf);
    vectors++;
    checkBit({name, ".empty"}, empty, e_empty);
    checkBit({name, ".full"}, full, e_full);
    checkBit({name, ".overflow"}, overflow, e_ovf);
    if (dout !== e_data) begin
      miscompares++;
      $display("[TB] FAIL %s.data: got %h, want %h", name, dout, e_data);
    end
    if (route !== e_route) begin
      miscompares++;
      $display("[TB] FAIL %s.route: got %0d, want %0d", name, route, e_route);
    end
  endtask

  initial begin
    logic [7:0] q[$];
    logic [7:0] v;
    logic [7:0] e;

    // wr, din, rd | empty, full, data, route, overflow
    vecs[0]  = '{1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0};
    vecs[1]  = '{1'b1, 8'h22, 1'b0, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0};
    vecs[2]  = '{1'b1, 8'h33, 1'b0, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0};
    vecs[3]  = '{1'b1, 8'h44, 1'b0, 1'b0, 1'b1, 8'h00, 3'd0, 1'b0};
    vecs[4]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h11, 3'd4, 1'b0};
    vecs[5]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h22, 3'd4, 1'b0};
    vecs[6]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h33, 3'd4, 1'b0};
    vecs[7]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h44, 3'd1, 1'b0};
    vecs[8]  = '{1'b1, 8'h7A, 1'b1, 1'b0, 1'b0, 8'h44, 3'd1, 1'b0};
    vecs[9]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h7A, 3'd3, 1'b0};
    vecs[10] = '{1'b1, 8'h90, 1'b0, 1'b0, 1'b0, 8'h7A, 3'd3, 1'b0};
    vecs[11] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h90, 3'd2, 1'b0};
    vecs[12] = '{1'b1, 8'h10, 1'b0, 1'b0, 1'b0, 8'h90, 3'd2, 1'b0};
    vecs[13] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h10, 3'd4, 1'b0};
    vecs[14] = '{1'b1, 8'h60, 1'b0, 1'b0, 1'b0, 8'h10, 3'd4, 1'b0};
    vecs[15] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h60, 3'd3, 1'b0};
    vecs[16] = '{1'b1, 8'h40, 1'b0, 1'b0, 1'b0, 8'h60, 3'd3, 1'b0};
    vecs[17] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h40, 3'd1, 1'b0};
    vecs[18] = '{1'b1, 8'h50, 1'b0, 1'b0, 1'b0, 8'h40, 3'd1, 1'b0};
    vecs[19] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h50, 3'd0, 1'b0};

    wr_en = 1'b0;
    rd_en = 1'b0;
    din   = 8'h00;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset", 1'b1, 1'b0, 8'h00, 3'd0, 1'b0);
`ifdef INPUT_BUF_ALMOST_FULL_EN
    vectors++;
    checkBit("reset.almost_full", almost_full, 1'b0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    // Fill/drain, empty-edge no-bypass, then the routing headers.
    for (int i = 0; i < 20; i++) begin
      applyStimulus(vecs[i].wr, vecs[i].din, vecs[i].rd);
      checkOutput($sformatf("vec%0d", i), vecs[i].e_empty, vecs[i].e_full,
                  vecs[i].e_data, vecs[i].e_route, vecs[i].e_ovf);
    end

    // Pointer wrap: hold occupancy at 2 through 10 push+pop pairs.
    applyStimulus(1'b1, 8'hA1, 1'b0);
    q.push_back(8'hA1);
    applyStimulus(1'b1, 8'h3C, 1'b0);
    q.push_back(8'h3C);
    checkOutput("wrap.pre", 1'b0, 1'b0, 8'h50, 3'd0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      v = 8'(i * 37 + 11);
      applyStimulus(1'b1, v, 1'b1);
      e = q.pop_front();
      q.push_back(v);
      checkOutput($sformatf("wrap%0d", i), 1'b0, 1'b0, e, exp_route(e), 1'b0);
    end
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b0, 8'h00, 1'b1);
      e = q.pop_front();
      checkOutput($sformatf("wrap.drain%0d", i), (i == 1), 1'b0, e, exp_route(e), 1'b0);
    end

    // Overflow: write while full with a same-cycle pop drops the flit.
    for (int i = 1; i <= 4; i++) begin
      applyStimulus(1'b1, 8'(i), 1'b0);
    end
    checkOutput("ovf.full", 1'b0, 1'b1, e, exp_route(e), 1'b0);
    applyStimulus(1'b1, 8'h55, 1'b1);
    checkOutput("ovf.drop", 1'b0, 1'b0, 8'h01, exp_route(8'h01), 1'b1);
    applyStimulus(1'b1, 8'h66, 1'b0);
    checkOutput("ovf.count3", 1'b0, 1'b1, 8'h01, exp_route(8'h01), 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("ovf.order", 1'b0, 1'b0, 8'h02, exp_route(8'h02), 1'b1);

    // Asynchronous reset mid-traffic takes effect without a clock edge.
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("rst.async", 1'b1, 1'b0, 8'h00, 3'd0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("rst.empty_pop", 1'b1, 1'b0, 8'h00, 3'd0, 1'b0);

`ifdef INPUT_BUF_ALMOST_FULL_EN
    applyStimulus(1'b1, 8'hC1, 1'b0);
    applyStimulus(1'b1, 8'hC2, 1'b0);
    vectors++;
    checkBit("af.count2", almost_full, 1'b0);
    applyStimulus(1'b1, 8'hC3, 1'b0);
    vectors++;
    checkBit("af.count3", almost_full, 1'b1);
    checkBit("af.count3.full", full, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b1);
    vectors++;
    checkBit("af.after_pop", almost_full, 1'b0);
    checkOutput("af.pop", 1'b0, 1'b0, 8'hC1, exp_route(8'hC1), 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
